// File: rtl/router_pkt_reader_pkg.sv
// Shared router constants, FSM encoding and the XOR-parity helper.
package router_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned HDR_ADDR_W  = 2;
  localparam int unsigned MAX_LEN     = 63;
  localparam int unsigned LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  // len+1 reaches 64, so the byte-left counters need one extra bit
  localparam int unsigned LEFT_W      = LEN_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_BODY  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    HDR   = ST_HDR,
    BODY  = ST_BODY,
    CHECK = ST_CHECK
  } state_t;

  // One step of the running packet parity (header ^ payload ^ parity == 0).
  function automatic logic [BYTE_W-1:0] parity_step(input logic [BYTE_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_pkt_reader_if.sv
// FIFO read handshake plus the outgoing payload stream of one router port.
interface router_pkt_reader_if;
  import router_pkg::*;

  logic              vld_out;
  logic [BYTE_W-1:0] data_out;
  logic              hold;
  logic              read_enb;
  logic [BYTE_W-1:0] pay_data;
  logic              pay_valid;

  modport slave (
    input  vld_out, data_out, hold,
    output read_enb, pay_data, pay_valid
  );

  modport master (
    output vld_out, data_out, hold,
    input  read_enb, pay_data, pay_valid
  );

endinterface

// File: rtl/router_pkt_reader_sat_counter.sv
// Saturating incrementer used for the packet and error counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count enabled events, sticking at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Drains one router output FIFO, parses packets, streams payload and
// reports per-packet parity/timeout status with running counters.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  router_pkt_reader_if.slave    bus,
  output logic                  pkt_done,
  output logic                  pkt_err,
  output logic                  pkt_timeout,
  output logic [HDR_ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]      pkt_len,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              rd_q;
  logic [BYTE_W-1:0] parity;
  logic [LEFT_W-1:0] req_left;
  logic [LEFT_W-1:0] rcv_left;
  logic [TO_W-1:0]   to_cnt;

  logic              want_c;
  logic              accept_c;
  logic              last_c;
  logic              to_hit_c;
  logic              fin_c;
  logic              err_c;
  logic [BYTE_W-1:0] par_nxt_c;
  logic [LEFT_W-1:0] hdr_left_c;

  // Whether the current state is allowed to pop another byte.
  always_comb begin
    want_c = 1'b0;
    case (state)
      IDLE:    want_c = 1'b1;
      BODY:    want_c = (req_left != '0);
      default: want_c = 1'b0;
    endcase
  end

  // Pop request is combinational so a byte can be taken every cycle.
  assign bus.read_enb = bus.vld_out & ~bus.hold & want_c & ~reset;
  assign accept_c     = bus.read_enb;

  assign par_nxt_c  = parity_step(parity, bus.data_out);
  assign hdr_left_c = LEFT_W'(bus.data_out[HDR_LEN_MSB:HDR_LEN_LSB]) + LEFT_W'(1);
  assign last_c     = (state == BODY) && rd_q && (rcv_left == LEFT_W'(1));
  assign to_hit_c   = ((state == HDR) || (state == BODY)) && !rd_q &&
                      (to_cnt == TO_W'(TIMEOUT - 1));
  assign fin_c      = last_c | to_hit_c;
  assign err_c      = to_hit_c | (last_c & (par_nxt_c != '0));

  // Packet FSM with its counters, parity and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rd_q          <= 1'b0;
      parity        <= '0;
      req_left      <= '0;
      rcv_left      <= '0;
      to_cnt        <= '0;
      bus.pay_data  <= '0;
      bus.pay_valid <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_err       <= 1'b0;
      pkt_timeout   <= 1'b0;
      pkt_addr      <= '0;
      pkt_len       <= '0;
    end else begin
      rd_q          <= accept_c;
      bus.pay_valid <= 1'b0;
      pkt_done      <= fin_c;
      pkt_err       <= err_c;
      pkt_timeout   <= to_hit_c;

      if ((state == HDR) || (state == BODY)) begin
        to_cnt <= rd_q ? '0 : to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            parity <= '0;
            state  <= HDR;
          end
        end
        HDR: begin
          if (rd_q) begin
            pkt_addr <= bus.data_out[HDR_ADDR_W-1:0];
            pkt_len  <= bus.data_out[HDR_LEN_MSB:HDR_LEN_LSB];
            parity   <= bus.data_out;
            req_left <= hdr_left_c;
            rcv_left <= hdr_left_c;
            state    <= BODY;
          end else if (to_hit_c) begin
            state <= CHECK;
          end
        end
        BODY: begin
          if (accept_c) begin
            req_left <= req_left - LEFT_W'(1);
          end
          if (rd_q) begin
            rcv_left <= rcv_left - LEFT_W'(1);
            parity   <= par_nxt_c;
            if (rcv_left > LEFT_W'(1)) begin
              bus.pay_valid <= 1'b1;
              bus.pay_data  <= bus.data_out;
            end
          end
          if (fin_c) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clock (clock),
    .reset (reset),
    .en    (fin_c),
    .q     (pkt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .en    (err_c),
    .q     (err_cnt)
  );

endmodule

// File: tb/tb_router_pkt_reader.sv
// Bench for router_pkt_reader: FIFO model, packet-level scoreboard, directed tests.
module tb_router_pkt_reader;
  import router_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [1:0] addr;
    logic [5:0] len;
    logic       err;
    logic       to;
  } rec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_pkt_reader_if bus ();

  logic          pkt_done, pkt_err, pkt_timeout;
  logic [1:0]    pkt_addr;
  logic [5:0]    pkt_len;
  logic [CW-1:0] pkt_cnt, err_cnt;

  router_pkt_reader #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .pkt_done    (pkt_done),
    .pkt_err     (pkt_err),
    .pkt_timeout (pkt_timeout),
    .pkt_addr    (pkt_addr),
    .pkt_len     (pkt_len),
    .pkt_cnt     (pkt_cnt),
    .err_cnt     (err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo[$];
  logic [7:0] exp_pay[$];
  rec_t       exp_rec[$];
  logic [CW-1:0] m_cnt = '0;
  logic [CW-1:0] m_err = '0;

  logic hold_v = 1'b0;
  logic acc_s = 1'b0;
  logic acc_prev = 1'b0;
  int cyc = 0, last_pv = 0, pv_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic last_err = 1'b0, last_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Queue a packet into the FIFO and derive its expected outcome.
  task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr,
                          input int n_pay, input bit corrupt);
    logic [7:0] hdr, par, b;
    rec_t r;
    hdr = {len, addr};
    par = parity_step(8'h00, hdr);
    fifo.push_back(hdr);
    for (int i = 0; i < n_pay; i++) begin
      b = 8'($urandom);
      fifo.push_back(b);
      exp_pay.push_back(b);
      par = parity_step(par, b);
    end
    r.addr = addr;
    r.len  = len;
    if (n_pay < int'(len)) begin
      r.err = 1'b1;
      r.to  = 1'b1;
    end else begin
      fifo.push_back(corrupt ? (par ^ 8'h01) : par);
      r.err = corrupt;
      r.to  = 1'b0;
    end
    exp_rec.push_back(r);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(posedge clock);
      n++;
    end
    if (done_cnt < target) fail({name, " timed out waiting for pkt_done"});
    #1;
  endtask

  task automatic wait_pv(input int target, input string name);
    int n = 0;
    while (pv_cnt < target && n < 2000) begin
      @(posedge clock);
      n++;
    end
    if (pv_cnt < target) fail({name, " timed out waiting for pay_valid"});
  endtask

  // Record each accepted read as seen just before the clock edge.
  always @(posedge clock) acc_s <= bus.read_enb & bus.vld_out;

  // Scoreboard compare, then FIFO model drive, away from the active edge.
  always @(negedge clock) begin
    rec_t r;
    cyc++;
    check("rd_gate", 32'(bus.read_enb & (bus.hold | ~bus.vld_out)), 32'd0);
    if (bus.pay_valid) begin
      pv_cnt++;
      last_pv = cyc;
      check("pay_latency", 32'(acc_prev), 32'd1);
      if (exp_pay.size() == 0) fail("pay_extra");
      else check("pay_data", 32'(bus.pay_data), 32'(exp_pay.pop_front()));
    end
    if (pkt_done) begin
      done_cnt++;
      done_cyc = cyc;
      last_err = pkt_err;
      last_to  = pkt_timeout;
      if (exp_rec.size() == 0) begin
        fail("pkt_extra");
      end else begin
        r = exp_rec.pop_front();
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
        if (r.err && (m_err != {CW{1'b1}})) m_err = m_err + CW'(1);
        check("done_addr", 32'(pkt_addr), 32'(r.addr));
        check("done_len", 32'(pkt_len), 32'(r.len));
        check("done_err", 32'(pkt_err), 32'(r.err));
        check("done_timeout", 32'(pkt_timeout), 32'(r.to));
        check("done_pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
        check("done_err_cnt", 32'(err_cnt), 32'(m_err));
      end
    end
    acc_prev = acc_s;
    if (acc_s) begin
      if (fifo.size() != 0) bus.data_out = fifo.pop_front();
      else if (!reset) fail("fifo_underflow");
    end
    bus.vld_out = (fifo.size() != 0);
    bus.hold    = hold_v;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tgt;
    reset        = 1'b1;
    bus.vld_out  = 1'b0;
    bus.hold     = 1'b0;
    bus.data_out = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_read_enb", 32'(bus.read_enb), 32'd0);
    check("rst_pay_valid", 32'(bus.pay_valid), 32'd0);
    check("rst_pay_data", 32'(bus.pay_data), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_err", 32'(pkt_err), 32'd0);
    check("rst_timeout", 32'(pkt_timeout), 32'd0);
    check("rst_addr", 32'(pkt_addr), 32'd0);
    check("rst_len", 32'(pkt_len), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(posedge clock);

    // Clean 16-byte packet, header 8'h40.
    base = pv_cnt; tgt = done_cnt + 1;
    send_pkt(6'd16, 2'd0, 16, 1'b0);
    wait_done(tgt, "clean");
    check("clean_pay_count", 32'(pv_cnt - base), 32'd16);
    check("clean_len", 32'(pkt_len), 32'd16);
    check("clean_addr", 32'(pkt_addr), 32'd0);
    check("clean_cnt", 32'(pkt_cnt), 32'd1);
    check("clean_err", 32'(last_err), 32'd0);

    // Zero-length packet: header 8'h02, parity 8'h02.
    base = pv_cnt; tgt = done_cnt + 1;
    send_pkt(6'd0, 2'd2, 0, 1'b0);
    wait_done(tgt, "zero_len");
    check("zero_pay_count", 32'(pv_cnt - base), 32'd0);
    check("zero_addr", 32'(pkt_addr), 32'd2);
    check("zero_err", 32'(last_err), 32'd0);
    check("zero_cnt", 32'(pkt_cnt), 32'd2);

    // Corrupted parity followed back-to-back by a clean packet.
    tgt = done_cnt + 2;
    send_pkt(6'd3, 2'd1, 3, 1'b1);
    send_pkt(6'd9, 2'd2, 9, 1'b0);
    wait_done(tgt, "corrupt");
    check("corrupt_err_cnt", 32'(err_cnt), 32'd1);
    check("corrupt_cnt", 32'(pkt_cnt), 32'd4);
    check("after_corrupt_len", 32'(pkt_len), 32'd9);
    check("after_corrupt_err", 32'(last_err), 32'd0);

    // Hold for 5 cycles mid-payload.
    base = pv_cnt; tgt = done_cnt + 1;
    send_pkt(6'd20, 2'd1, 20, 1'b0);
    wait_pv(base + 5, "hold_start");
    hold_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      check("hold_read_enb", 32'(bus.read_enb), 32'd0);
    end
    hold_v = 1'b0;
    wait_done(tgt, "hold");
    check("hold_pay_count", 32'(pv_cnt - base), 32'd20);

    // vld_out rises together with hold.
    @(posedge clock);
    tgt = done_cnt + 1;
    hold_v = 1'b1;
    send_pkt(6'd2, 2'd3, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("rise_hold_read_enb", 32'(bus.read_enb), 32'd0);
    end
    @(posedge clock);
    hold_v = 1'b0;
    wait_done(tgt, "rise_hold");

    // Truncated packet: header 8'h14, 3 of 5 payload bytes.
    tgt = done_cnt + 1;
    send_pkt(6'd5, 2'd0, 3, 1'b0);
    wait_done(tgt, "timeout");
    check("to_timeout", 32'(last_to), 32'd1);
    check("to_err", 32'(last_err), 32'd1);
    check("to_gap", 32'(done_cyc - last_pv), 32'd8);
    check("to_err_cnt", 32'(err_cnt), 32'd2);
    check("to_len", 32'(pkt_len), 32'd5);

    // Asynchronous reset in the middle of a body.
    base = pv_cnt;
    send_pkt(6'd20, 2'd3, 20, 1'b0);
    wait_pv(base + 4, "reset_start");
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_read_enb", 32'(bus.read_enb), 32'd0);
    check("mid_rst_pay_valid", 32'(bus.pay_valid), 32'd0);
    check("mid_rst_pay_data", 32'(bus.pay_data), 32'd0);
    check("mid_rst_done", 32'(pkt_done), 32'd0);
    check("mid_rst_addr", 32'(pkt_addr), 32'd0);
    check("mid_rst_len", 32'(pkt_len), 32'd0);
    check("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    fifo.delete();
    exp_pay.delete();
    exp_rec.delete();
    m_cnt = '0;
    m_err = '0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    base = pv_cnt; tgt = done_cnt + 1;
    send_pkt(6'd7, 2'd2, 7, 1'b0);
    wait_done(tgt, "post_reset");
    check("post_rst_pay_count", 32'(pv_cnt - base), 32'd7);
    check("post_rst_cnt", 32'(pkt_cnt), 32'd1);
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("post_rst_addr", 32'(pkt_addr), 32'd2);

    repeat (4) @(posedge clock);
    check("left_pay", 32'(exp_pay.size()), 32'd0);
    check("left_rec", 32'(exp_rec.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
